dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port read-first data block RAM. It shares the RAM between the CPU load/store unit (port 0) and the UART loader/IO DMA (port 1), issues at most one access per cycle, and returns read data one cycle after grant. It sits between the requesters and the RAM's `en`/`we`/`addr`/`di`/`dout` pins, and flags out-of-range accesses.

## Interface
- `ADDR_W`, 32: word-address width of both ports and the RAM.
- `DATA_W`, 32: data width.
- `DEPTH`, 140001: number of RAM words. Valid addresses are 0..DEPTH-1.
- `STARVE_MAX`, 8: number of consecutive denied cycles after which port 1 is forced through (only with the starvation macro).

- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `p0_req`, `p1_req` in 1: request valid.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in ADDR_W: word address.
- `p0_wdata`, `p1_wdata` in DATA_W: write data.
- `p0_gnt`, `p1_gnt` out 1: combinational grant; the request is accepted this cycle.
- `p0_rvalid`, `p1_rvalid` out 1: registered; read data is valid this cycle.
- `p0_rdata`, `p1_rdata` out DATA_W: read data. Driven from `ram_dout` when the port's rvalid is high; 0 otherwise.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_W, `ram_di` out DATA_W: RAM controls. Combinational from the grant.
- `ram_dout` in DATA_W: RAM output. Valid one cycle after `ram_en`.
- `oor_err` out 1: sticky out-of-range flag. Cleared only by `rst`.

## Operation
- Requester rule: hold `req`, `we`, `addr`, and `wdata` stable until the cycle in which `gnt` is high. Deasserting `req` before grant is legal and withdraws the request. No request is queued inside the block.
- Arbitration is fixed priority, port 0 over port 1. At most one grant per cycle, and never both.
- Grant with an in-range address:
  - `ram_en` = 1.
  - `ram_we` = the port's `we`.
  - `ram_addr` = the port's `addr`; `ram_di` = the port's `wdata`.
- No grant: `ram_en` = 0 and `ram_we` = 0; `ram_addr` and `ram_di` are 0.
- Granted read: a registered tag (`rd_pend`, `rd_owner`) records the owner. The next cycle, that owner's `rvalid` = 1 and its `rdata` = `ram_dout`.
- Granted write: completes at grant and produces no rvalid.
- Out-of-range grant (`addr` ≥ DEPTH):
  - The grant is still given, but `ram_en` = 0.
  - `oor_err` sets.
  - A read still produces `rvalid` the next cycle, with `rdata` = 0.
- Back-to-back reads from either port are sustained at one per cycle. A grant in the same cycle as an rvalid is legal.
- State: `rd_pend`, `rd_owner`, `oor_q`, `oor_err`, and `starve_cnt` (see Configuration).

## Timing
- Grant latency: 0 cycles, combinational from `req` and priority state.
- Read latency: exactly 1 cycle from the granting edge to `rvalid`. The rvalid pulse lasts exactly 1 cycle.
- Reset values:
  - All `rvalid` = 0, all `rdata` = 0.
  - `oor_err` = 0.
  - `starve_cnt` = 0, `rd_pend` = 0, `rd_owner` = 0.
  - `ram_en`, `ram_we` = 0 while `rst` is high, regardless of requests; all grants = 0 while `rst` is high.
- Reset mid-read: the pending rvalid is dropped, and no rvalid is issued after reset releases.
- Simultaneous `p0_req` and `p1_req`: the winner is decided by the priority rule (and the starvation override when compiled in). The loser sees `gnt` = 0 and must hold its request.
- Write then read of the same address on consecutive grants: the read returns the new data (RAM write completes at the edge).
- Read and write on the same grant never occur, since one access per cycle.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - `starve_cnt` (width $clog2(STARVE_MAX+1)) increments each cycle in which `p1_req` = 1 and `p1_gnt` = 0.
  - When `starve_cnt` == STARVE_MAX, port 1 wins the next contended cycle, even against `p0_req`.
  - `starve_cnt` clears on any `p1_gnt`, or whenever `p1_req` = 0.
  - It saturates and never wraps.
- Not defined: pure fixed priority; `starve_cnt` is absent, and port 1 can be starved indefinitely.

## Test plan
- Reset check: assert `rst` with both ports requesting -> no grant, `ram_en` = 0, all rvalid = 0, `oor_err` = 0. Release `rst` -> `p0_gnt` = 1 in the same cycle.
- Port 0 round trip: write 0xDEADBEEF to address 100, then read address 100 -> `p0_rvalid` = 1 exactly 1 cycle after the read grant, with `p0_rdata` = 0xDEADBEEF; `p1_rvalid` stays 0.
- Contention: both ports read every cycle for 20 cycles.
  - Without the macro: only `p0_gnt` for all 20 cycles.
  - With the macro and STARVE_MAX = 8: `p1_gnt` in cycle 9, 18, …, and `p1_rvalid` the following cycle.
- Out-of-range read: read at address 140001 -> granted, `ram_en` = 0, `rvalid` the next cycle with data 0. `oor_err` = 1 and stays 1 through subsequent valid accesses until `rst`.
- Reset mid-read: grant a read, then assert `rst` before the next edge -> no rvalid ever appears for that read.
- Streaming: alternate port 0 read and port 1 read on consecutive cycles (port 0 idle on odd cycles) -> each port's rvalid follows its own grant by 1 cycle, with the correct data and no cross-delivery.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Fixed-priority two-port arbiter/sequencer for a single-port read-first data RAM (port 0 wins).
// Define DMEM_ARB_STARVE_EN to force port 1 through after STARVE_MAX consecutive denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 140001,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              oor_err
);
    localparam logic [63:0] DEPTH_L = 64'(DEPTH);

    logic              p1_force;
    logic              gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic oor_q, oor_d;
    logic oor_err_q, oor_err_d;

`ifdef DMEM_ARB_STARVE_EN
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign p1_force = (starve_cnt_q == CNT_MAX);

    // Counts consecutive denied cycles of a live port 1 request; saturates at CNT_MAX.
    always_comb begin
        starve_cnt_d = '0;
        if (p1_req && !p1_gnt)
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    assign p1_force = 1'b0;
`endif

    always_comb begin
        p1_gnt = !rst && p1_req && (!p0_req || p1_force);
        p0_gnt = !rst && p0_req && !p1_gnt;
    end

    assign gnt_any   = p0_gnt || p1_gnt;
    assign sel_we    = p1_gnt ? p1_we    : p0_we;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign in_range  = (64'(sel_addr) < DEPTH_L);

    // Out-of-range grants are accepted but never reach the RAM.
    assign ram_en   = gnt_any && in_range;
    assign ram_we   = ram_en && sel_we;
    assign ram_addr = ram_en ? sel_addr  : '0;
    assign ram_di   = ram_en ? sel_wdata : '0;

    always_comb begin
        rd_pend_d  = gnt_any && !sel_we;
        rd_owner_d = gnt_any ? p1_gnt : rd_owner_q;
        oor_d      = gnt_any && !in_range;
        oor_err_d  = oor_err_q || (gnt_any && !in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            oor_q      <= 1'b0;
            oor_err_q  <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            oor_q      <= oor_d;
            oor_err_q  <= oor_err_d;
        end
    end

    // A pending out-of-range read returns zero instead of whatever the RAM last drove.
    assign p0_rvalid = rd_pend_q && !rd_owner_q;
    assign p1_rvalid = rd_pend_q && rd_owner_q;
    assign p0_rdata  = (p0_rvalid && !oor_q) ? ram_dout : '0;
    assign p1_rdata  = (p1_rvalid && !oor_q) ? ram_dout : '0;
    assign oor_err   = oor_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle reference model plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 140001;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              ram_en, ram_we, oor_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_dout = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    // Read-first RAM; the output register holds its last value while not enabled.
    logic [DATA_W-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr[7:0]];
            if (ram_we)
                ram_mem[ram_addr[7:0]] <= ram_di;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: full-address memory, pending-read record, sticky error, starvation count.
    bit [31:0] ref_mem [bit [31:0]];
    bit        m_pend, m_owner, m_oor, m_err;
    bit [31:0] m_data;
    int        m_starve;
    bit        g0, g1, gany, force1, inr, gwe;
    bit [31:0] ga, gd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_p0_gnt", 64'(p0_gnt), 64'd0);
            chk("rst_p1_gnt", 64'(p1_gnt), 64'd0);
            chk("rst_ram_en", 64'(ram_en), 64'd0);
            chk("rst_ram_we", 64'(ram_we), 64'd0);
            chk("rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
            chk("rst_p1_rvalid", 64'(p1_rvalid), 64'd0);
            chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
            chk("rst_p1_rdata", 64'(p1_rdata), 64'd0);
            chk("rst_oor_err", 64'(oor_err), 64'd0);
            m_pend = 0; m_owner = 0; m_oor = 0; m_err = 0; m_starve = 0; m_data = 0;
        end else begin
            force1 = 0;
`ifdef DMEM_ARB_STARVE_EN
            force1 = (m_starve >= STARVE_MAX);
`endif
            g1   = p1_req && (!p0_req || force1);
            g0   = p0_req && !g1;
            gany = g0 || g1;
            ga   = g1 ? p1_addr : p0_addr;
            gd   = g1 ? p1_wdata : p0_wdata;
            gwe  = g1 ? p1_we : p0_we;
            inr  = ga < 32'(DEPTH);

            chk("m_p0_gnt", 64'(p0_gnt), 64'(g0));
            chk("m_p1_gnt", 64'(p1_gnt), 64'(g1));
            chk("m_ram_en", 64'(ram_en), 64'(gany && inr));
            chk("m_ram_we", 64'(ram_we), 64'(gany && inr && gwe));
            if (!(gany && !inr)) begin
                chk("m_ram_addr", 64'(ram_addr), 64'(gany ? ga : 32'd0));
                chk("m_ram_di", 64'(ram_di), 64'(gany ? gd : 32'd0));
            end
            chk("m_p0_rvalid", 64'(p0_rvalid), 64'(m_pend && !m_owner));
            chk("m_p1_rvalid", 64'(p1_rvalid), 64'(m_pend && m_owner));
            chk("m_p0_rdata", 64'(p0_rdata), 64'((m_pend && !m_owner && !m_oor) ? m_data : 32'd0));
            chk("m_p1_rdata", 64'(p1_rdata), 64'((m_pend && m_owner && !m_oor) ? m_data : 32'd0));
            chk("m_oor_err", 64'(oor_err), 64'(m_err));

            if (gany && !inr)
                m_err = 1;
            m_pend  = gany && !gwe;
            m_owner = g1;
            m_oor   = !inr;
            m_data  = 0;
            if (gany && inr) begin
                if (gwe)
                    ref_mem[ga] = gd;
                else
                    m_data = ref_mem.exists(ga) ? ref_mem[ga] : 32'd0;
            end
            if (p1_req && !g1)
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else
                m_starve = 0;
        end
    end

    task automatic drive(input logic r,
                         input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pre(input int k);
        return 32'hA500_0000 | (32'(k) * 32'h111);
    endfunction

    initial begin
        logic        exp1, prev1;
        int          prev_port, prev_k, k;

        // Reset held with both ports requesting.
        drive(1, 1, 0, 5, 0, 1, 0, 6, 0);
        chk("rst_hold_p0_gnt", 64'(p0_gnt), 64'd0);
        chk("rst_hold_ram_en", 64'(ram_en), 64'd0);
        drive(1, 1, 0, 5, 0, 1, 0, 6, 0);
        drive(0, 1, 0, 5, 0, 1, 0, 6, 0);
        chk("rel_p0_gnt", 64'(p0_gnt), 64'd1);
        chk("rel_p1_gnt", 64'(p1_gnt), 64'd0);

        // Port 0 write then read-back.
        drive(0, 1, 1, 100, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("wr_ram_we", 64'(ram_we), 64'd1);
        chk("wr_ram_addr", 64'(ram_addr), 64'd100);
        drive(0, 1, 0, 100, 0, 0, 0, 0, 0);
        chk("rd_p0_gnt", 64'(p0_gnt), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rt_p0_rvalid", 64'(p0_rvalid), 64'd1);
        chk("rt_p0_rdata", 64'(p0_rdata), 64'hDEADBEEF);
        chk("rt_p1_rvalid", 64'(p1_rvalid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rt_pulse_once", 64'(p0_rvalid), 64'd0);

        // Last in-range word through port 1.
        drive(0, 0, 0, 0, 0, 1, 1, 140000, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 1, 0, 140000, 0);
        chk("top_ram_en", 64'(ram_en), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("top_p1_rvalid", 64'(p1_rvalid), 64'd1);
        chk("top_p1_rdata", 64'(p1_rdata), 64'h1234_5678);
        chk("top_oor_err", 64'(oor_err), 64'd0);

        // Contention: both ports read every cycle for 20 cycles.
        prev1 = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 100, 0, 1, 0, 140000, 0);
            exp1 = 0;
`ifdef DMEM_ARB_STARVE_EN
            exp1 = (i == 8) || (i == 17);
`endif
            chk("cont_p1_gnt", 64'(p1_gnt), 64'(exp1));
            chk("cont_p0_gnt", 64'(p0_gnt), 64'(!exp1));
            chk("cont_p1_rvalid", 64'(p1_rvalid), 64'(prev1));
            prev1 = exp1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range read; error stays set through later valid accesses.
        drive(0, 1, 0, 140001, 0, 0, 0, 0, 0);
        chk("oor_p0_gnt", 64'(p0_gnt), 64'd1);
        chk("oor_ram_en", 64'(ram_en), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_rvalid", 64'(p0_rvalid), 64'd1);
        chk("oor_rdata", 64'(p0_rdata), 64'd0);
        chk("oor_err_set", 64'(oor_err), 64'd1);
        drive(0, 1, 0, 100, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_after_rdata", 64'(p0_rdata), 64'hDEADBEEF);
        chk("oor_err_sticky", 64'(oor_err), 64'd1);

        // Reset asserted between a read grant and its return edge.
        drive(0, 1, 0, 100, 0, 0, 0, 0, 0);
        chk("mid_p0_gnt", 64'(p0_gnt), 64'd1);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rvalid_rst", 64'(p0_rvalid), 64'd0);
        chk("mid_oor_clr", 64'(oor_err), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rvalid_post", 64'(p0_rvalid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Preload 200..205 through port 1, then alternate port 0 / port 1 reads.
        for (int j = 0; j < 6; j++)
            drive(0, 0, 0, 0, 0, 1, 1, 200 + j, pre(j));
        prev_port = -1;
        prev_k = 0;
        for (int c = 0; c < 12; c++) begin
            k = (c / 2) % 6;
            if (c % 2 == 0)
                drive(0, 1, 0, 200 + k, 0, 0, 0, 0, 0);
            else
                drive(0, 0, 0, 0, 0, 1, 0, 200 + (5 - k), 0);
            if (prev_port == 0) begin
                chk("str_p0_rvalid", 64'(p0_rvalid), 64'd1);
                chk("str_p0_rdata", 64'(p0_rdata), 64'(pre(prev_k)));
                chk("str_p1_quiet", 64'(p1_rvalid), 64'd0);
            end else if (prev_port == 1) begin
                chk("str_p1_rvalid", 64'(p1_rvalid), 64'd1);
                chk("str_p1_rdata", 64'(p1_rdata), 64'(pre(prev_k)));
                chk("str_p0_quiet", 64'(p0_rvalid), 64'd0);
            end
            prev_port = c % 2;
            prev_k = (c % 2 == 0) ? k : 5 - k;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("str_last_p1_rvalid", 64'(p1_rvalid), 64'd1);
        chk("str_last_p1_rdata", 64'(p1_rdata), 64'(pre(prev_k)));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
